uart_rx_fifo: RTL

User-project UART receiver that sits downstream of the testbench UART transmitter on mprj_io[5]. It deserialises 8N1 frames, buffers them in a small FIFO and raises a level interrupt toward the management core. The firmware's UART handler drains the buffered bytes through a valid/ready read port. The interrupt is the one the bench triggers with its random-delay UART send that runs alongside the QS/MM/FIR workloads.

---
 rtl/uart_rx_fifo.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver with show-ahead receive FIFO and level interrupt
// Bytes that fail the stop check or arrive while the FIFO is full are dropped and flagged.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clock,
  input  logic                          resetb,
  input  logic                          rx,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  input  logic                          irq_en,
  output logic                          irq,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overrun,
  input  logic                          err_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW:0]   DEPTH_V = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic          rx_meta, rx_s;
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shreg, shreg_n;
  logic          stop_done;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          full, pop, push_req, push, ovr_evt, ferr_evt;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shreg <= shreg_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    shreg_n   = shreg;
    stop_done = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          cnt_n   = HALF_M1;
          state_n = START;
        end
      end
      START: begin
        if (cnt != '0) begin
          cnt_n = cnt - CNT_ONE;
        end else if (rx_s) begin
          state_n = IDLE;
        end else begin
          cnt_n   = FULL_M1;
          idx_n   = 3'd0;
          state_n = DATA;
        end
      end
      DATA: begin
        if (cnt != '0) begin
          cnt_n = cnt - CNT_ONE;
        end else begin
          shreg_n = {rx_s, shreg[7:1]};
          cnt_n   = FULL_M1;
          if (idx == 3'd7) state_n = STOP;
          else             idx_n   = idx + 3'd1;
        end
      end
      STOP: begin
        if (cnt != '0) begin
          cnt_n = cnt - CNT_ONE;
        end else begin
          stop_done = 1'b1;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // A simultaneous pop frees the slot, so a full FIFO still accepts the byte.
  assign fifo_count = wr_ptr - rd_ptr;
  assign rd_valid   = (fifo_count != '0);
  assign full       = (fifo_count == DEPTH_V);
  assign pop        = rd_valid && rd_ready;
  assign push_req   = stop_done && rx_s;
  assign push       = push_req && (!full || pop);
  assign ovr_evt    = push_req && full && !pop;
  assign ferr_evt   = stop_done && !rx_s;
  assign rd_data    = rd_valid ? mem[rd_ptr[AW-1:0]] : 8'h00;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= shreg;
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      irq       <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW + 1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);
      irq <= irq_en && rd_valid;
      if (ferr_evt)     frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
      if (ovr_evt)      overrun   <= 1'b1;
      else if (err_clr) overrun   <= 1'b0;
    end
  end

endmodule
